// File: rtl/serial_addsub_ctrl_pkg.sv
// rtl/serial_addsub_ctrl_pkg.sv - shared state and opcode encodings for the serial add/sub sequencer
package serial_addsub_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_subtractor.sv
// rtl/adder_subtractor.sv - one-bit full adder with B inversion for subtract
module adder_subtractor (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic sel,
    output logic sum,
    output logic cout
);

    logic b_eff;

    assign b_eff = b ^ sel;
    assign sum   = a ^ b_eff ^ cin;
    assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial N-bit add/sub sequencer around one adder_subtractor cell
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             op_q;
    logic             carry_q;
    logic             c_msb_q;
    logic             cell_sum;
    logic             cell_cout;
    logic             last_bit;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    adder_subtractor u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sel  (op_q),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Carry preset to op supplies the +1 of two's-complement subtraction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        op_q    <= op;
                        carry_q <= op;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= {cell_sum, res_q[WIDTH-1:1]};
                    carry_q <= cell_cout;
                    if (last_bit) begin
                        c_msb_q <= carry_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Carry and MSB carry-in are left untouched outside SHIFT, so the flags hold until the next accept.
    always_comb begin
        busy     = (state_q == SHIFT);
        done     = (state_q == DONE);
        result   = res_q;
        cout_out = carry_q;
        overflow = c_msb_q ^ carry_q;
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - self-checking bench for serial_addsub_ctrl
module tb_serial_addsub_ctrl;
    import serial_addsub_ctrl_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout_out;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout_out (cout_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic plus sign-rule overflow.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                         output logic [W-1:0] r, output logic c, output logic v);
        int unsigned s;
        if (o == OP_SUB) s = int'(a) + ((1 << W) - int'(b));
        else             s = int'(a) + int'(b);
        r = s[W-1:0];
        c = s[W];
        if (o == OP_SUB) v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        else             v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                          input bit poke_shift, input bit poke_done);
        logic [W-1:0] er;
        logic ec, ev;
        int edges;
        bit busy_ok;
        model(a, b, o, er, ec, ev);
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; op = o;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        busy_ok = 1'b1;
        while (!done && edges < 20) begin
            if (!busy) busy_ok = 1'b0;
            if (poke_shift && edges == 3) begin
                start = 1'b1; a_in = ~a; b_in = ~b; op = ~o;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        check("latency", edges, 9);
        check("busy_during_shift", busy_ok, 1);
        check("done_busy_exclusive", busy, 0);
        check("result", result, er);
        check("cout_out", cout_out, ec);
        check("overflow", overflow, ev);
        if (poke_done) begin
            start = 1'b1; a_in = 8'hAA; b_in = 8'h55; op = ~o;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        @(negedge clk);
        check("no_restart", {busy, done}, 2'b00);
        check("result_hold", result, er);
        check("cout_hold", cout_out, ec);
        check("overflow_hold", overflow, ev);
    endtask

    initial begin
        logic [W-1:0] er;
        logic ec, ev;
        logic [W-1:0] ra, rb;
        logic ro;
        int gap;
        int dones;
        bit saw_done;

        #12;
        check("reset_result", result, 0);
        check("reset_flags", {busy, done, cout_out, overflow}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h25, 8'h17, OP_ADD, 0, 0);
        run_op(8'h7F, 8'h01, OP_ADD, 0, 0);
        run_op(8'hFF, 8'h01, OP_ADD, 0, 0);
        run_op(8'h10, 8'h20, OP_SUB, 0, 0);
        run_op(8'h80, 8'h01, OP_SUB, 0, 0);
        run_op(8'h5A, 8'h33, OP_ADD, 1, 1);

        // Abort mid-operation with an asynchronous reset after four bit steps.
        @(negedge clk);
        start = 1'b1; a_in = 8'hC3; b_in = 8'h7E; op = OP_ADD;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_result", result, 0);
        check("rst_async_flags", {busy, done, cout_out, overflow}, 4'b0000);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("rst_no_done", saw_done, 0);
        run_op(8'h03, 8'h04, OP_ADD, 0, 0);

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            ro = 1'($urandom);
            run_op(ra, rb, ro, 0, 0);
        end

        // Back-to-back with start held high; operands change only at done.
        @(negedge clk);
        ra = W'($urandom); rb = W'($urandom); ro = 1'($urandom);
        start = 1'b1; a_in = ra; b_in = rb; op = ro;
        dones = 0;
        gap = 0;
        for (int cyc = 0; cyc < 60 && dones < 5; cyc++) begin
            @(negedge clk);
            gap++;
            if (done) begin
                model(ra, rb, ro, er, ec, ev);
                check("b2b_result", result, er);
                check("b2b_cout", cout_out, ec);
                check("b2b_overflow", overflow, ev);
                if (dones == 0) check("b2b_first_latency", gap, 9);
                else            check("b2b_period", gap, 10);
                dones++;
                gap = 0;
                ra = W'($urandom); rb = W'($urandom); ro = 1'($urandom);
                a_in = ra; b_in = rb; op = ro;
            end
        end
        check("b2b_count", dones, 5);
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
